// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multiply/divide unit for the E stage of the pipelined MIPS core.
//
// Executes mult/multu/div/divu and the accumulate ops madd/maddu/msub/msubu
// over a fixed number of cycles, owns the HI/LO registers and services
// mthi/mtlo.  Busy tells the hazard unit to stall mfhi/mflo and any later
// MDU instruction.
//
// Handshake: an op is accepted on any rising edge where Busy=0 and MDUOp
// holds a valid code; while Busy=1 MDUOp is ignored entirely (mthi/mtlo too).
//
// Ports:
//   clk    in   1      system clock, all state updates on rising edge
//   reset  in   1      synchronous active-high reset
//   A      in   WIDTH  rs operand
//   B      in   WIDTH  rt operand
//   MDUOp  in   4      operation code (see OP_* below)
//   Busy   out  1      high while a multi-cycle op is in flight
//   HI     out  WIDTH  HI register
//   LO     out  WIDTH  LO register
// -----------------------------------------------------------------------------
module mdu #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       MDUOp,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [3:0] OP_MULT  = 4'b0001;
   localparam logic [3:0] OP_MULTU = 4'b0010;
   localparam logic [3:0] OP_DIV   = 4'b0011;
   localparam logic [3:0] OP_DIVU  = 4'b0100;
   localparam logic [3:0] OP_MADD  = 4'b0101;
   localparam logic [3:0] OP_MADDU = 4'b0110;
   localparam logic [3:0] OP_MSUB  = 4'b0111;
   localparam logic [3:0] OP_MSUBU = 4'b1000;
   localparam logic [3:0] OP_MTHI  = 4'b1001;
   localparam logic [3:0] OP_MTLO  = 4'b1010;

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   // Result datapath, driven only by latched operands and the HI/LO flops.
   // HI/LO cannot change during RUN, so hi_q/lo_q are the accumulate base.
   logic [2*WIDTH-1:0]      prod_s, prod_u, acc, res;
   logic                    div_by_zero, div_ovf;
   logic [WIDTH-1:0]        b_safe_s, b_safe_u, quo_u, rem_u;
   logic signed [WIDTH-1:0] quo_s, rem_s;

   always_comb begin
      prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      acc    = {hi_q, lo_q};

      div_by_zero = (b_q == '0);
      div_ovf     = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
      // Boundary cases are substituted below; feed the dividers a harmless
      // divisor so they never see /0 or the signed overflow pair.
      b_safe_s = (div_by_zero || div_ovf) ? WIDTH'(1) : b_q;
      b_safe_u = div_by_zero ? WIDTH'(1) : b_q;
      quo_s    = $signed(a_q) / $signed(b_safe_s);
      rem_s    = $signed(a_q) % $signed(b_safe_s);
      quo_u    = a_q / b_safe_u;
      rem_u    = a_q % b_safe_u;

      res = acc;
      case (op_q)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_MADD:  res = acc + prod_s;
         OP_MADDU: res = acc + prod_u;
         OP_MSUB:  res = acc - prod_s;
         OP_MSUBU: res = acc - prod_u;
         OP_DIV: begin
            if (div_by_zero)  res = {a_q, {WIDTH{1'b1}}};
            else if (div_ovf) res = {{WIDTH{1'b0}}, a_q};
            else              res = {rem_s, quo_s};
         end
         OP_DIVU: begin
            if (div_by_zero)  res = {a_q, {WIDTH{1'b1}}};
            else              res = {rem_u, quo_u};
         end
         default:  res = acc;
      endcase
   end

   // Next-state / output logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            case (MDUOp)
               OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                  a_d     = A;
                  b_d     = B;
                  op_d    = MDUOp;
                  cnt_d   = CW'(MULT_CYCLES);
                  state_d = S_RUN;
               end
               OP_DIV, OP_DIVU: begin
                  a_d     = A;
                  b_d     = B;
                  op_d    = MDUOp;
                  cnt_d   = CW'(DIV_CYCLES);
                  state_d = S_RUN;
               end
               OP_MTHI: hi_d = A;
               OP_MTLO: lo_d = A;
               default: ;
            endcase
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            // cnt==1 marks the final edge of the op's N cycles.
            if (cnt_q == CW'(1)) begin
               hi_d    = res[2*WIDTH-1:WIDTH];
               lo_d    = res[WIDTH-1:0];
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy = (state_q == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu (WIDTH=32, 5 mult / 10 div cycles).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] A, B;
   logic [3:0]  MDUOp;
   logic        Busy;
   logic [31:0] HI, LO;

   int vectors = 0;
   int fails   = 0;

   // reference copy of HI/LO
   logic [31:0] hi_m, lo_m;

   mdu #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .MDUOp (MDUOp),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural model: {HI,LO} as a 64-bit value, plain integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                                 output logic [31:0] nh, nl);
      longint      sp;
      logic [63:0] up, acc, r;
      int          sa, sb, sq;
      sa  = $signed(a);
      sb  = $signed(b);
      sp  = longint'(sa) * longint'(sb);
      up  = {32'd0, a} * {32'd0, b};
      acc = {hi, lo};
      case (op)
         4'd1:  r = sp;
         4'd2:  r = up;
         4'd5:  r = acc + sp;
         4'd6:  r = acc + up;
         4'd7:  r = acc - sp;
         4'd8:  r = acc - up;
         4'd3: begin
            if (b == 32'd0)                                  r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, a};
            else begin
               sq = sa / sb;
               r  = {32'(sa - sq * sb), 32'(sq)};
            end
         end
         4'd4: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {a % b, a / b};
         end
         4'd9:  r = {a, lo};
         4'd10: r = {hi, a};
         default: r = acc;
      endcase
      nh = r[63:32];
      nl = r[31:0];
   endfunction

   // Issue one op and follow it to completion. noisy=1 scribbles on the
   // inputs (mthi 0xDEAD and random codes) while Busy is high.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, input bit noisy);
      logic [31:0] eh, el;
      int n;
      model(op, a, b, hi_m, lo_m, eh, el);
      n = (op == 4'd3 || op == 4'd4) ? DC : ((op >= 4'd1 && op <= 4'd8) ? MC : 0);
      @(negedge clk);
      MDUOp = op; A = a; B = b;
      @(posedge clk);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("busy_run", {63'd0, Busy}, 64'd1);
         check("hilo_hold", {HI, LO}, {hi_m, lo_m});
         if (noisy) begin
            MDUOp = (k % 2 == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            A     = (k == 0) ? 32'h0000_DEAD : $urandom;
            B     = $urandom;
         end else begin
            MDUOp = 4'd0;
         end
      end
      @(negedge clk);
      MDUOp = 4'd0;
      check("busy_done", {63'd0, Busy}, 64'd0);
      check("hilo_result", {HI, LO}, {eh, el});
      hi_m = eh;
      lo_m = el;
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      // reset then idle
      reset = 1'b1; MDUOp = 4'd0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      hi_m = '0; lo_m = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("reset_idle", {31'd0, Busy, HI, LO}, 64'd0);
      end

      // mult / multu
      do_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      check("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

      // divides incl. boundaries
      do_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(4'd4, 32'h0000_0007, 32'h0000_0000, 1'b0);
      check("divu_zero", {HI, LO}, 64'h0000_0007_FFFF_FFFF);
      do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
      do_op(4'd3, 32'h0000_0005, 32'h0000_0000, 1'b0);
      check("div_zero", {HI, LO}, 64'h0000_0005_FFFF_FFFF);

      // mthi/mtlo and accumulate
      do_op(4'd9, 32'h0000_0001, 32'h0, 1'b0);
      do_op(4'd10, 32'hFFFF_FFFF, 32'h0, 1'b0);
      check("mthi_mtlo", {HI, LO}, 64'h0000_0001_FFFF_FFFF);
      do_op(4'd6, 32'h1, 32'h1, 1'b0);
      check("maddu_const", {HI, LO}, 64'h0000_0002_0000_0000);
      do_op(4'd7, 32'h1, 32'h1, 1'b0);
      check("msub_const", {HI, LO}, 64'h0000_0001_FFFF_FFFF);

      // ops ignored while busy, operands changing underneath
      do_op(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      do_op(4'd4, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

      // reset two cycles into a div
      @(negedge clk);
      MDUOp = 4'd3; A = 32'd100; B = 32'd7;
      @(posedge clk);
      @(negedge clk);
      MDUOp = 4'd0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_reset", {31'd0, Busy, HI, LO}, 64'd0);
      hi_m = '0; lo_m = '0;
      do_op(4'd1, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0);
      check("mult_after_reset", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

      // randomized ops against the model
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Parametrised multiply/divide unit that sits beside the ALU in the E stage of the pipelined MIPS core.
- Executes mult/multu/div/divu plus the accumulate ops madd/maddu/msub/msubu over a configurable number of cycles.
- Owns the HI/LO registers and services mthi/mtlo.
- Exposes Busy so the hazard unit can stall mfhi/mflo and any later MDU instruction.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- MDUOp  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 madd, 0110 maddu, 0111 msub, 1000 msubu, 1001 mthi, 1010 mtlo, others treated as none.
- Busy  output  1  high while a multi-cycle operation is in flight.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset: at any rising edge with reset=1, HI=0, LO=0, Busy=0, counter=0. This aborts any in-flight op with no HI/LO update. reset has priority over everything.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, down-counter cnt).
- IDLE, MDUOp sampled each rising edge:
  - ops 0001-1000: latch A, B, op, HI, LO; load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - mthi: HI<=A at that edge, LO unchanged, stay IDLE.
  - mtlo: LO<=A at that edge, HI unchanged, stay IDLE.
  - none or unused: no change.
- RUN:
  - cnt decrements each edge.
  - On the edge where cnt reaches 1, HI/LO receive the result and the state returns to IDLE.
  - Op sampled at edge T0: Busy=1 from just after T0 up to edge T0+N; HI/LO take the result at edge T0+N; Busy=0 after T0+N. N is the op's cycle count.
  - A new op may be accepted in the cycle right after Busy falls.
- Op sampled on the same edge as a result write: not possible, since Busy=1 in that cycle.
- MDUOp is ignored while Busy=1, including mthi/mtlo. The hazard unit guarantees a stall; the bench checks for silent drop.
- Results are computed from the latched operands only. A/B changes during RUN have no effect.
- Result arithmetic (P = 2*WIDTH-bit product, {HI,LO} treated as a 2*WIDTH-bit value):
  - mult: {HI,LO}=signed A*B.
  - multu: {HI,LO}=unsigned A*B.
  - madd/maddu: {HI,LO}=latched {HI,LO}+P, with signed/unsigned P. Wraps mod 2^(2*WIDTH).
  - msub/msubu: {HI,LO}=latched {HI,LO}-P. Wraps mod 2^(2*WIDTH).
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of A.
  - divu: LO=unsigned quotient, HI=unsigned remainder.
- Divide boundary cases:
  - Divide by zero (div or divu): LO=all ones, HI=A.
  - Signed overflow (A=most negative, B=-1): LO=A, HI=0.
- HI and LO are register outputs with no combinational path from inputs.

Test Plan:
- Reset then idle: hold reset 2 cycles, MDUOp=0 -> HI=0, LO=0, Busy=0 for 10 cycles.
- mult A=0xFFFFFFFF B=0x00000002 at edge T0 -> Busy high cycles T0+1..T0+5; at edge T0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7) B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=0 -> LO=0xFFFFFFFF, HI=7. div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x1, mtlo A=0xFFFFFFFF, then maddu A=1 B=1 -> HI=0x2, LO=0x0. Then msub A=1 B=1 -> HI=0x1, LO=0xFFFFFFFF.
- While Busy: drive mthi A=0xDEAD and change A/B every cycle -> HI/LO equal the original op's result; 0xDEAD never appears.
- Assert reset 2 cycles into a div -> next cycle Busy=0, HI=0, LO=0. A new mult accepted immediately afterwards completes normally.
